// File: rtl/ppe_stm_pkg.sv
// Shared widths and request/response types for the STM lookup block.
package ppe_stm_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 64;
  localparam int TAG_W_DEF      = 6;
  localparam int RD_LAT_DEF     = 2;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [TAG_W_DEF-1:0]  tag;
  } stm_req_t;

  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
    logic                  par_err;
  } stm_rsp_t;

endpackage

// File: rtl/ppe_stm_lkup_if.sv
// Request, STM read and response channels of the lookup block.
interface ppe_stm_lkup_if
  import ppe_stm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_par;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_par_err;

  modport slave (
    input  req_valid, req_addr, req_tag, mem_rd_data, mem_rd_par, rsp_ready,
    output req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_tag, rsp_data, rsp_par_err
  );

  modport master (
    output req_valid, req_addr, req_tag, mem_rd_data, mem_rd_par, rsp_ready,
    input  req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_tag, rsp_data, rsp_par_err
  );

endinterface

// File: rtl/ppe_stm_lkup_fifo.sv
// Synchronous response FIFO; power-of-two depth so pointers wrap naturally.
module ppe_stm_lkup_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     cclk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge cclk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ppe_stm_lkup.sv
// Credit-gated STM lookup: fixed-latency read, tag pipe, in-order response FIFO.
// Optional per-entry parity checking enabled by defining PPE_STM_LKUP_PARITY_EN.
module ppe_stm_lkup
  import ppe_stm_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               cclk,
  input  logic               rst_n,
  ppe_stm_lkup_if.slave      bus,
  output logic [31:0]        lkup_cnt,
  output logic [15:0]        par_err_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 1 + TAG_W + DATA_W;

  logic                          accept;
  logic [ADDR_W-1:0]             addr_w;
  logic [RD_LAT-1:0]             vld_pipe_q;
  logic [RD_LAT-1:0][TAG_W-1:0]  tag_pipe_q;
  logic                          push, pop, full, empty, wr_perr;
  logic [CNT_W-1:0]              fifo_cnt;
  logic [ENT_W-1:0]              wr_ent, rd_ent;
  logic [15:0]                   used;
  logic [31:0]                   lkup_cnt_q, lkup_cnt_d;
  logic                          unused_full;

  // Credits come only from registered state, so a pop frees a slot one cycle later.
  always_comb begin
    used = 16'(fifo_cnt);
    for (int i = 0; i < RD_LAT; i++) used = used + 16'(vld_pipe_q[i]);
  end

  assign bus.req_ready   = rst_n & (used < 16'(FIFO_DEPTH));
  assign accept          = bus.req_valid & bus.req_ready;
  assign addr_w          = bus.req_addr;
  assign bus.mem_rd_en   = accept;
  assign bus.mem_rd_addr = addr_w;

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= accept;
      tag_pipe_q[0] <= bus.req_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  assign push   = vld_pipe_q[RD_LAT-1];
  assign pop    = bus.rsp_valid & bus.rsp_ready;
  assign wr_ent = {wr_perr, tag_pipe_q[RD_LAT-1], bus.mem_rd_data};

  ppe_stm_lkup_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .cclk    (cclk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_ent),
    .pop_i   (pop),
    .rdata_o (rd_ent),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );

  assign unused_full   = full;
  assign bus.rsp_valid = ~empty;
  assign bus.rsp_data  = rd_ent[DATA_W-1:0];
  assign bus.rsp_tag   = rd_ent[DATA_W +: TAG_W];

  always_comb begin
    lkup_cnt_d = lkup_cnt_q;
    if (accept && lkup_cnt_q != '1) lkup_cnt_d = lkup_cnt_q + 32'd1;
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) lkup_cnt_q <= '0;
    else        lkup_cnt_q <= lkup_cnt_d;
  end

  assign lkup_cnt = lkup_cnt_q;

`ifdef PPE_STM_LKUP_PARITY_EN
  logic [15:0] perr_cnt_q, perr_cnt_d;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign wr_perr = ^bus.mem_rd_data ^ bus.mem_rd_par;

  always_comb begin
    perr_cnt_d = perr_cnt_q;
    if (push && wr_perr && perr_cnt_q != '1) perr_cnt_d = perr_cnt_q + 16'd1;
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) perr_cnt_q <= '0;
    else        perr_cnt_q <= perr_cnt_d;
  end

  assign par_err_cnt     = perr_cnt_q;
  assign bus.rsp_par_err = ~empty & rd_ent[ENT_W-1];
`else
  logic unused_par;

  assign wr_perr         = 1'b0;
  assign unused_par      = ^{bus.mem_rd_par, rd_ent[ENT_W-1]};
  assign par_err_cnt     = 16'h0;
  assign bus.rsp_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ppe_stm_lkup.sv
// Scoreboard bench for ppe_stm_lkup with a fixed-latency STM model.
module tb_ppe_stm_lkup;
  import ppe_stm_pkg::*;

  logic        cclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lkup_cnt;
  logic [15:0] par_err_cnt;

  ppe_stm_lkup_if #(.ADDR_W(ADDR_W_DEF), .DATA_W(DATA_W_DEF), .TAG_W(TAG_W_DEF)) bus ();

  ppe_stm_lkup #(
    .ADDR_W(ADDR_W_DEF), .DATA_W(DATA_W_DEF), .TAG_W(TAG_W_DEF),
    .RD_LAT(2), .FIFO_DEPTH(4)
  ) dut (
    .cclk        (cclk),
    .rst_n       (rst_n),
    .bus         (bus),
    .lkup_cnt    (lkup_cnt),
    .par_err_cnt (par_err_cnt)
  );

  always #5 cclk = ~cclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [11:0] a);
    if (a == 12'h005) return 64'hA5;
    if (a == 12'h3FF) return 64'h1;
    return {16'hC0DE, 36'h0, a} ^ {a, 52'h0};
  endfunction

  function automatic logic mem_par(input logic [11:0] a);
    return (a == 12'h3FF) ? 1'b0 : ^mem_data(a);
  endfunction

  function automatic logic exp_perr(input logic [11:0] a);
`ifdef PPE_STM_LKUP_PARITY_EN
    return ^mem_data(a) ^ mem_par(a);
`else
    return (a == 12'hFFF) & 1'b0;
`endif
  endfunction

  // STM model: two-cycle read latency, keeps returning data across reset.
  logic [11:0] m1_a = '0, m2_a = '0;
  always @(posedge cclk) begin
    m1_a <= bus.mem_rd_addr;
    m2_a <= m1_a;
  end
  assign bus.mem_rd_data = mem_data(m2_a);
  assign bus.mem_rd_par  = mem_par(m2_a);

  stm_rsp_t exp_q[$];
  stm_rsp_t mon_e;
  int       pop_cyc_q[$];
  int       acc_cnt = 0;
  int       cyc = 0;

  always @(posedge cclk) cyc <= cyc + 1;

  always @(negedge cclk) begin
    if (rst_n) begin
      if (bus.req_valid && bus.req_ready) begin
        chk("rd_en", 64'(bus.mem_rd_en), 64'd1);
        chk("rd_addr", 64'(bus.mem_rd_addr), 64'(bus.req_addr));
        exp_q.push_back('{tag: bus.req_tag, data: mem_data(bus.req_addr),
                          par_err: exp_perr(bus.req_addr)});
        acc_cnt++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexp", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rsp_tag", 64'(bus.rsp_tag), 64'(mon_e.tag));
          chk("rsp_data", bus.rsp_data, mon_e.data);
          chk("rsp_perr", 64'(bus.rsp_par_err), 64'(mon_e.par_err));
          pop_cyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    bus.rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    if (n >= max) chk("drain_to", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send(input stm_req_t r);
    bus.req_valid = 1'b1;
    bus.req_addr  = r.addr;
    bus.req_tag   = r.tag;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, seen, i, guard;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();

    @(negedge cclk);
    chk("rst_rdy", 64'(bus.req_ready), 64'd0);
    chk("rst_rden", 64'(bus.mem_rd_en), 64'd0);
    chk("rst_rv", 64'(bus.rsp_valid), 64'd0);
    chk("rst_perr", 64'(bus.rsp_par_err), 64'd0);
    chk("rst_lkup", 64'(lkup_cnt), 64'd0);
    chk("rst_pcnt", 64'(par_err_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    @(negedge cclk);
    chk("rdy_rel", 64'(bus.req_ready), 64'd1);

    // single request, latency measured from the accept cycle
    bus.rsp_ready = 1'b1;
    tick();
    send('{addr: 12'h005, tag: 6'd3});
    tick();
    bus.req_valid = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge cclk);
      if (bus.rsp_valid) break;
      n++;
      @(posedge cclk);
    end
    chk("lat", 64'(n), 64'd3);
    drain(20);

    // back-pressure: six back-to-back requests against a stalled consumer
    bus.rsp_ready = 1'b0;
    a0 = acc_cnt;
    for (int k = 0; k < 6; k++) begin
      send('{addr: 12'h010 + 12'(k), tag: 6'(k)});
      tick();
    end
    bus.req_valid = 1'b0;
    repeat (6) tick();
    @(negedge cclk);
    chk("bp_acc", 64'(acc_cnt - a0), 64'd4);
    chk("bp_rdy", 64'(bus.req_ready), 64'd0);
    chk("bp_rv", 64'(bus.rsp_valid), 64'd1);
    chk("bp_q", 64'(exp_q.size()), 64'd4);

    // release: one pop, credit visible only on the following cycle
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge cclk);
    chk("rel_same", 64'(bus.req_ready), 64'd0);
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge cclk);
    chk("rel_next", 64'(bus.req_ready), 64'd1);
    chk("rel_q", 64'(exp_q.size()), 64'd3);
    drain(20);

    // parity: data 0x1 returned with parity bit 0
    tick();
    send('{addr: 12'h3FF, tag: 6'd5});
    tick();
    bus.req_valid = 1'b0;
    drain(20);
    @(negedge cclk);
`ifdef PPE_STM_LKUP_PARITY_EN
    chk("perr_cnt", 64'(par_err_cnt), 64'd1);
`else
    chk("perr_cnt", 64'(par_err_cnt), 64'd0);
`endif

    // reset with two reads in flight
    bus.rsp_ready = 1'b0;
    tick();
    send('{addr: 12'h040, tag: 6'd7});
    tick();
    send('{addr: 12'h041, tag: 6'd8});
    tick();
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge cclk);
      if (bus.rsp_valid) seen++;
    end
    chk("mrst_rv", 64'(seen), 64'd0);
    chk("mrst_lkup", 64'(lkup_cnt), 64'd0);
    chk("mrst_pcnt", 64'(par_err_cnt), 64'd0);

    // streaming: continuous valid/ready, tags 0..15
    tick();
    pop_cyc_q.delete();
    i = 0;
    guard = 0;
    while (i < 16 && guard < 64) begin
      send('{addr: 12'h020 + 12'(i), tag: 6'(i)});
      @(negedge cclk);
      if (bus.req_ready) i++;
      tick();
      guard++;
    end
    bus.req_valid = 1'b0;
    chk("st_cyc", 64'(guard), 64'd16);
    drain(30);
    chk("st_n", 64'(pop_cyc_q.size()), 64'd16);
    if (pop_cyc_q.size() == 16) chk("st_span", 64'(pop_cyc_q[15] - pop_cyc_q[0]), 64'd15);
    @(negedge cclk);
    chk("st_lkup", 64'(lkup_cnt), 64'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppe_stm_lkup.md
PPE_STM_LKUP -- requirements
Module: ppe_stm_lkup

Interface
REQ-001 Parameter SHALL be ADDR_W, default 12, STM read address width.
REQ-002 Parameter SHALL be DATA_W, default 64, STM read data width.
REQ-003 Parameter SHALL be TAG_W, default 6, requester tag width.
REQ-004 Parameter SHALL be RD_LAT, default 2, fixed STM read latency in cycles, legal range 1..4.
REQ-005 Parameter SHALL be FIFO_DEPTH, default 4, response buffer entries, power of two, minimum 2.
REQ-006 Port SHALL be cclk  in  1  sole clock; all logic on its rising edge.
REQ-007 Port SHALL be rst_n  in  1  synchronous, active-low reset.
REQ-008 Port SHALL be req_valid  in  1  lookup request valid.
REQ-009 Port SHALL be req_ready  out  1  request accept.
REQ-010 Port SHALL be req_addr  in  ADDR_W  STM entry address.
REQ-011 Port SHALL be req_tag  in  TAG_W  opaque tag returned with the response.
REQ-012 Port SHALL be mem_rd_en  out  1  STM read strobe.
REQ-013 Port SHALL be mem_rd_addr  out  ADDR_W  STM read address.
REQ-014 Port SHALL be mem_rd_data  in  DATA_W  STM read data, valid RD_LAT cycles after mem_rd_en.
REQ-015 Port SHALL be mem_rd_par  in  1  even parity over mem_rd_data, same timing as mem_rd_data.
REQ-016 Port SHALL be rsp_valid  out  1  response valid.
REQ-017 Port SHALL be rsp_ready  in  1  downstream accept.
REQ-018 Port SHALL be rsp_tag  out  TAG_W  tag of the head response.
REQ-019 Port SHALL be rsp_data  out  DATA_W  lookup data.
REQ-020 Port SHALL be rsp_par_err  out  1  parity error flag on the head response.
REQ-021 Port SHALL be lkup_cnt  out  32  accepted-request count, saturating.
REQ-022 Port SHALL be par_err_cnt  out  16  parity-error count, saturating.

Function
REQ-023 The block SHALL define credits as FIFO_DEPTH minus (in-flight reads plus FIFO occupancy), computed from registered state only.
REQ-024 req_ready SHALL be 1 if and only if credits > 0; a pop in the same cycle SHALL NOT add credit until the next cycle.
REQ-025 A request SHALL be accepted on a cycle where req_valid & req_ready; mem_rd_en SHALL equal that accept and mem_rd_addr SHALL equal req_addr combinationally, in the same cycle.
REQ-026 The tag and a valid bit SHALL travel through an RD_LAT-stage shift pipeline aligned to mem_rd_data; returned data SHALL be written to the FIFO on the cycle the pipeline valid exits.
REQ-027 Responses SHALL be delivered in acceptance order; the minimum latency from accept at cycle T to rsp_valid SHALL be T+RD_LAT+1.
REQ-028 rsp_valid SHALL be 1 whenever the FIFO is non-empty; head contents SHALL hold stable until rsp_valid & rsp_ready.
REQ-029 A FIFO write and pop in the same cycle SHALL both occur; occupancy SHALL be unchanged, including when the FIFO is full.
REQ-030 FIFO overflow SHALL be impossible by construction; the credit rule of REQ-023 SHALL guarantee this with rsp_ready held at 0 indefinitely.
REQ-031 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 lkup_cnt SHALL increment on each accept and hold at 0xFFFF_FFFF; par_err_cnt SHALL increment on each FIFO write with a parity error and hold at 0xFFFF.

Reset
REQ-033 While rst_n is 0 at a clock edge, all state SHALL clear: pipeline valids 0, FIFO empty, pointers 0, counters 0.
REQ-034 Outputs SHALL reset as follows: req_ready 0 while rst_n is low, mem_rd_en 0, rsp_valid 0, rsp_par_err 0, lkup_cnt 0, par_err_cnt 0; req_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-035 Reset asserted mid-operation SHALL discard in-flight reads; data returning after reset SHALL be ignored.

Configuration
REQ-036 With PPE_STM_LKUP_PARITY_EN defined, the block SHALL compute the error as XOR over mem_rd_data XOR mem_rd_par and store it per FIFO entry.
REQ-037 Without PPE_STM_LKUP_PARITY_EN, mem_rd_par SHALL be ignored, and rsp_par_err and par_err_cnt SHALL be constant 0.

Structure
REQ-038 Package ppe_stm_pkg SHALL hold the request and response struct typedefs (addr/tag and tag/data/par_err) and the default width constants.
REQ-039 The response buffer SHALL be the sub-module ppe_stm_lkup_fifo, a synchronous FIFO with push/pop/full/empty/count.

Verification
REQ-040 The bench SHALL cover single request: addr 0x005, tag 3, mem data 0xA5 -> rsp_valid at T+3 (RD_LAT=2), tag 3, data 0xA5, par_err 0.
REQ-041 The bench SHALL cover back-pressure: rsp_ready=0 with 6 back-to-back requests -> exactly 4 accepted, req_ready 0 afterward, no overflow.
REQ-042 The bench SHALL cover release: from the full state, rsp_ready=1 for one cycle -> one pop, req_ready 1 on the next cycle, not the same cycle.
REQ-043 The bench SHALL cover streaming: continuous valid and ready, tags 0..15 -> one response per cycle in order, lkup_cnt=16.
REQ-044 The bench SHALL cover parity (with the macro): data 0x1 with par 0 -> rsp_par_err 1 and par_err_cnt 1; without the macro -> both 0.
REQ-045 The bench SHALL cover reset: rst_n low with 2 reads in flight -> rsp_valid stays 0 after release, counters 0.
